// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, NZCV bit positions and the
// occupancy encoding used by the result-stage skid buffer.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV derivation from an adder result; shared with the
// branch-compare unit, so it carries no state.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             ovf,
    output logic [3:0]       flags
);

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: 2-entry skid buffer with NZCV capture and an
// architectural flags register. Optional sticky overflow under ALU_STICKY_OVF_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [RD_W-1:0]  out_rd,
`ifdef ALU_STICKY_OVF_EN
    output logic             sticky_ovf,
    input  logic             clr_sticky,
`endif
    output logic [3:0]       flags_q
);

    occ_t             state_q, state_d;
    logic             load_main, load_skid, main_from_skid;
    logic             in_xfer, out_xfer;
    logic [3:0]       in_flags;

    logic [WIDTH-1:0] main_result_q, skid_result_q;
    logic [3:0]       main_flags_q,  skid_flags_q;
    logic [RD_W-1:0]  main_rd_q,     skid_rd_q;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result (in_result),
        .carry  (in_carry),
        .ovf    (in_overflow),
        .flags  (in_flags)
    );

    // Both handshake outputs decode straight from the occupancy register.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign out_result = main_result_q;
    assign out_flags  = main_flags_q;
    assign out_rd     = main_rd_q;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (out_xfer) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            main_result_q <= '0;
            main_flags_q  <= '0;
            main_rd_q     <= '0;
            skid_result_q <= '0;
            skid_flags_q  <= '0;
            skid_rd_q     <= '0;
            flags_q       <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_result_q <= in_result;
                main_flags_q  <= in_flags;
                main_rd_q     <= in_rd;
            end else if (main_from_skid) begin
                main_result_q <= skid_result_q;
                main_flags_q  <= skid_flags_q;
                main_rd_q     <= skid_rd_q;
            end
            if (load_skid) begin
                skid_result_q <= in_result;
                skid_flags_q  <= in_flags;
                skid_rd_q     <= in_rd;
            end
            if (out_xfer) begin
                flags_q <= main_flags_q;
            end
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // A V=1 transfer outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (out_xfer && main_flags_q[FLAG_V]) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag vectors, back-pressure ordering,
// async reset from a full buffer, and sticky overflow when ALU_STICKY_OVF_EN is set.
module tb_alu_result_stage;

    localparam int WIDTH = 64;
    localparam int RD_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_overflow;
    logic [RD_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [RD_W-1:0]  out_rd;
    logic [3:0]       flags_q;
`ifdef ALU_STICKY_OVF_EN
    logic             sticky_ovf;
    logic             clr_sticky;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_rd      (out_rd),
`ifdef ALU_STICKY_OVF_EN
        .sticky_ovf  (sticky_ovf),
        .clr_sticky  (clr_sticky),
`endif
        .flags_q     (flags_q)
    );

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic [RD_W-1:0]  rd;
        logic [3:0]       exp_flags;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] r, input logic c, input logic v, input logic [RD_W-1:0] rd);
        in_valid    = 1'b1;
        in_result   = r;
        in_carry    = c;
        in_overflow = v;
        in_rd       = rd;
    endtask

    // Single transaction from EMPTY: capture, inspect, then drain with out_ready.
    task automatic push_one(input vec_t v, input int idx);
        out_ready = 1'b0;
        drive(v.result, v.carry, v.ovf, v.rd);
        tick();
        in_valid = 1'b0;
        check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'd1);
        check($sformatf("v%0d out_result", idx), out_result, v.result);
        check($sformatf("v%0d out_flags", idx), 64'(out_flags), 64'(v.exp_flags));
        check($sformatf("v%0d out_rd", idx), 64'(out_rd), 64'(v.rd));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("v%0d flags_q", idx), 64'(flags_q), 64'(v.exp_flags));
        check($sformatf("v%0d drained", idx), 64'(out_valid), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'd2,                  1'b1, 1'b0, 5'd1, 4'b0010}; // 7-5
        vecs[1] = '{64'd0,                  1'b1, 1'b0, 5'd2, 4'b0110}; // 5-5
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5'd3, 4'b1000}; // 5-7
        vecs[3] = '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 5'd4, 4'b1001}; // 7FFF..+1
        vecs[4] = '{64'd0,                  1'b1, 1'b0, 5'd5, 4'b0110}; // FFFF..+1
        vecs[5] = '{64'd0,                  1'b1, 1'b1, 5'd31, 4'b0111}; // 8000..+8000..

        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
        in_overflow = 1'b0; in_rd = '0; out_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        tick();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_result", out_result, 64'd0);
        check("rst out_flags", 64'(out_flags), 64'd0);
        check("rst out_rd", 64'(out_rd), 64'd0);
        check("rst flags_q", 64'(flags_q), 64'd0);
`ifdef ALU_STICKY_OVF_EN
        check("rst sticky", 64'(sticky_ovf), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) push_one(vecs[i], i);

        // Back-pressure: A, B accepted, C held until the buffer drains.
        out_ready = 1'b0;
        drive(64'hA, 1'b0, 1'b0, 5'd10);
        tick();
        check("bp A accepted in_ready", 64'(in_ready), 64'd1);
        drive(64'hB, 1'b0, 1'b0, 5'd11);
        tick();
        check("bp full in_ready", 64'(in_ready), 64'd0);
        check("bp head A", out_result, 64'hA);
        drive(64'h8000_0000_0000_000C, 1'b1, 1'b0, 5'd12);
        tick();
        check("bp held in_ready", 64'(in_ready), 64'd0);
        check("bp stall stable", out_result, 64'hA);
        check("bp stall rd", 64'(out_rd), 64'd10);
        out_ready = 1'b1;
        tick();
        check("bp second B", out_result, 64'hB);
        check("bp second valid", 64'(out_valid), 64'd1);
        check("bp flags_q after A", 64'(flags_q), 64'd0);
        check("bp reopen in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp third C", out_result, 64'h8000_0000_0000_000C);
        check("bp third flags", 64'(out_flags), 64'(4'b1010));
        check("bp third valid", 64'(out_valid), 64'd1);
        tick();
        out_ready = 1'b0;
        check("bp empty", 64'(out_valid), 64'd0);
        check("bp flags_q after C", 64'(flags_q), 64'(4'b1010));

        // Fill to TWO, then reset asynchronously mid-cycle.
        drive(64'h11, 1'b1, 1'b0, 5'd1);
        tick();
        drive(64'h22, 1'b1, 1'b0, 5'd2);
        tick();
        in_valid = 1'b0;
        check("two in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst out_valid", 64'(out_valid), 64'd0);
        check("arst in_ready", 64'(in_ready), 64'd1);
        check("arst flags_q", 64'(flags_q), 64'd0);
        check("arst out_result", out_result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst idle", 64'(out_valid), 64'd0);
        drive(64'h33, 1'b1, 1'b0, 5'd3);
        tick();
        in_valid = 1'b0;
        check("post rst latency", 64'(out_valid), 64'd1);
        check("post rst data", out_result, 64'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post rst drained", 64'(out_valid), 64'd0);

`ifdef ALU_STICKY_OVF_EN
        push_one(vecs[3], 3);
        check("sticky set", 64'(sticky_ovf), 64'd1);
        push_one(vecs[0], 0);
        check("sticky hold", 64'(sticky_ovf), 64'd1);
        drive(vecs[3].result, vecs[3].carry, vecs[3].ovf, vecs[3].rd);
        tick();
        in_valid = 1'b0;
        clr_sticky = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        check("sticky set wins", 64'(sticky_ovf), 64'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("sticky clear", 64'(sticky_ovf), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
